// File: rtl/regfile_mp.sv
// regfile_mp: pipelined-core register file with two registered read ports,
// a general write port, a link ($ra) write port, a pending-write scoreboard,
// registered v0/a0 taps and a post-reset clear walk gated by ready.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_IDX = 31,
  parameter int V0_IDX   = 2,
  parameter int A0_IDX   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] v0,
  output logic [DATA_W-1:0] a0,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = LINK_IDX[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] V0_A   = V0_IDX[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] A0_A   = A0_IDX[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_A = '0;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    pending_q, pending_d;
  logic [DATA_W-1:0]   rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0]   rd_data2_q, rd_data2_d;
  logic [DATA_W-1:0]   v0_q, v0_d;
  logic [DATA_W-1:0]   a0_q, a0_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic run;
  logic gen_we;
  logic link_we;

  // Effective write strobes: dropped outside RUN and for register 0;
  // a general write to the link register shadows the link port.
  always_comb begin
    run     = (state_q == RUN);
    gen_we  = run && wr_en && (wr_addr != ZERO_A);
    link_we = run && link_en && (LINK_A != ZERO_A) && !(gen_we && (wr_addr == LINK_A));
  end

  // Value an entry will hold after this edge (write-through bypass).
  function automatic logic [DATA_W-1:0] next_val(input logic [ADDR_W-1:0] a);
    if (a == ZERO_A)                 return '0;
    else if (gen_we && wr_addr == a) return wr_data;
    else if (link_we && a == LINK_A) return link_data;
    else                             return mem_q[a];
  endfunction

  // Reservation visibility for the read ports; a same-cycle retiring write
  // hides the reservation unless a new one lands on the same register.
  always_comb begin
    busy1 = run && (rd_addr1 != ZERO_A) && pending_q[rd_addr1] &&
            !(wr_en && wr_addr == rd_addr1 && !(rsv_en && rsv_addr == rd_addr1));
    busy2 = run && (rd_addr2 != ZERO_A) && pending_q[rd_addr2] &&
            !(wr_en && wr_addr == rd_addr2 && !(rsv_en && rsv_addr == rd_addr2));
  end

  // Next-state logic for the clear walk, scoreboard and registered outputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    ready_d    = ready_q;
    rd_data1_d = '0;
    rd_data2_d = '0;
    v0_d       = '0;
    a0_d       = '0;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_A) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (link_we) pending_d[LINK_A]  = 1'b0;
        if (gen_we)  pending_d[wr_addr] = 1'b0;
        if (rsv_en && rsv_addr != ZERO_A) pending_d[rsv_addr] = 1'b1;
        rd_data1_d = next_val(rd_addr1);
        rd_data2_d = next_val(rd_addr2);
        v0_d       = next_val(V0_A);
        a0_d       = next_val(A0_A);
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      pending_q  <= '0;
      ready_q    <= 1'b0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      v0_q       <= '0;
      a0_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      ready_q    <= ready_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      v0_q       <= v0_d;
      a0_q       <= a0_d;
    end
  end

  // Storage array: cleared by the walk, written by the general and link ports.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the clear walk zeroes it, keeping it mappable to RAM.
    if (rst_n) begin
      if (state_q == CLEAR) mem_q[cnt_q]   <= '0;
      if (gen_we)           mem_q[wr_addr] <= wr_data;
      if (link_we)          mem_q[LINK_A]  <= link_data;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign v0       = v0_q;
  assign a0       = a0_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a behavioural model predicts each
// cycle's registered outputs, which are queued and compared after the edge.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic [DW-1:0] rd_data1, rd_data2, wr_data, link_data, v0, a0;
  logic          busy1, busy2, wr_en, link_en, rsv_en, ready;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .busy1(busy1), .busy2(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(link_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .v0(v0), .a0(a0), .ready(ready)
  );

  typedef struct {
    logic [DW-1:0] rd1, rd2, v0, a0;
    logic          ready;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_mem [D];
  logic [D-1:0]  m_pend;
  bit            m_run, m_known;
  int            m_cnt;
  int            n_total, n_bad;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_after(input logic [AW-1:0] a, input bit gw, input bit lw);
    if (a == 0)                      return '0;
    else if (gw && wr_addr == a)     return wr_data;
    else if (lw && a == 5'd31)       return link_data;
    else                             return m_mem[a];
  endfunction

  function automatic bit m_busy(input logic [AW-1:0] a);
    return m_run && a != 0 && m_pend[a] &&
           !(wr_en && wr_addr == a && !(rsv_en && rsv_addr == a));
  endfunction

  // One clock: predict, check busy, push expectation, advance model, pop and compare.
  task automatic cycle();
    exp_t e;
    bit   gw, lw;
    gw = m_run && wr_en && wr_addr != 0;
    lw = m_run && link_en && !(gw && wr_addr == 5'd31);
    #1;
    if (m_known) begin
      check("busy1", {31'd0, busy1}, {31'd0, m_busy(rd_addr1)});
      check("busy2", {31'd0, busy2}, {31'd0, m_busy(rd_addr2)});
    end
    if (!rst_n || !m_run) begin
      e.rd1 = '0; e.rd2 = '0; e.v0 = '0; e.a0 = '0;
      e.ready = rst_n && !m_run && m_cnt == D - 1;
    end else begin
      e.rd1 = m_after(rd_addr1, gw, lw);
      e.rd2 = m_after(rd_addr2, gw, lw);
      e.v0  = m_after(5'd2, gw, lw);
      e.a0  = m_after(5'd4, gw, lw);
      e.ready = 1'b1;
    end
    if (m_known || !rst_n) sb_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_pend = '0; m_known = 1;
    end else if (!m_run) begin
      if (m_known) begin
        m_mem[m_cnt] = '0;
        if (m_cnt == D - 1) m_run = 1;
        m_cnt = (m_cnt + 1) % D;
      end
    end else begin
      if (lw) begin m_mem[31] = link_data; m_pend[31] = 1'b0; end
      if (gw) begin m_mem[wr_addr] = wr_data; m_pend[wr_addr] = 1'b0; end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rd_data1", rd_data1, e.rd1);
      check("rd_data2", rd_data2, e.rd2);
      check("v0", v0, e.v0);
      check("a0", a0, e.a0);
      check("ready", {31'd0, ready}, {31'd0, e.ready});
    end
  endtask

  task automatic idle();
    wr_en = 0; link_en = 0; rsv_en = 0;
  endtask

  // Wait out the clear walk with a bounded loop; returns edges seen.
  task automatic wait_ready(output int edges);
    edges = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      edges++;
      if (ready) break;
    end
  endtask

  initial begin
    int edges;
    n_total = 0; n_bad = 0;
    m_run = 0; m_known = 0; m_cnt = 0; m_pend = '0;
    rst_n = 0; idle();
    rd_addr1 = 0; rd_addr2 = 0; wr_addr = 0; rsv_addr = 0;
    wr_data = 0; link_data = 0;
    @(posedge clk); #1;

    // Reset for two cycles, then count the clear walk.
    cycle(); cycle();
    rst_n = 1;
    wait_ready(edges);
    check("ready_latency", edges, 32);

    // All entries read as zero after the walk.
    for (int i = 0; i < D; i += 2) begin
      rd_addr1 = AW'(i); rd_addr2 = AW'(i + 1);
      cycle();
    end

    // General write with same-cycle bypass; register 0 stays zero.
    wr_en = 1; wr_addr = 8; wr_data = 32'hDEADBEEF; rd_addr1 = 8; rd_addr2 = 0;
    cycle();
    wr_addr = 0; wr_data = 32'h1234; rd_addr1 = 0; rd_addr2 = 8;
    cycle();
    idle(); cycle();

    // Link write alone, then link against a general write to $ra.
    link_en = 1; link_data = 32'h00400020; rd_addr1 = 31;
    cycle();
    idle(); cycle();
    link_en = 1; link_data = 32'h00400040; wr_en = 1; wr_addr = 31; wr_data = 32'h55;
    cycle();
    idle(); cycle();

    // Scoreboard on register 9.
    rd_addr1 = 9; rd_addr2 = 31;
    rsv_en = 1; rsv_addr = 9; cycle();
    idle(); cycle();
    check("busy1_after_rsv", {31'd0, busy1}, 32'd1);
    rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99; cycle();
    idle(); cycle();
    check("busy1_rsv_wins", {31'd0, busy1}, 32'd1);
    wr_en = 1; wr_addr = 9; wr_data = 7; cycle();
    check("rd_data1_retire", rd_data1, 32'd7);
    idle(); cycle();
    check("busy1_cleared", {31'd0, busy1}, 32'd0);

    // Syscall taps.
    wr_en = 1; wr_addr = 2; wr_data = 10; cycle();
    wr_addr = 4; wr_data = 32'hFF; cycle();
    check("v0_tap", v0, 32'd10);
    check("a0_tap", a0, 32'hFF);
    idle(); cycle();

    // Random traffic through the model.
    for (int n = 0; n < 300; n++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = ($urandom_range(0, 3) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
      wr_data   = $urandom;
      link_en   = ($urandom_range(0, 3) == 0);
      link_data = $urandom;
      rsv_en    = ($urandom_range(0, 2) == 0);
      rsv_addr  = AW'($urandom_range(0, 7));
      rd_addr1  = AW'($urandom_range(0, 7));
      rd_addr2  = ($urandom_range(0, 1) == 1) ? 5'd31 : AW'($urandom_range(0, 7));
      cycle();
    end
    idle();

    // Mid-operation reset discards that cycle's write and restarts the walk.
    wr_en = 1; wr_addr = 5; wr_data = 32'hAA; rd_addr1 = 5; cycle();
    idle(); cycle();
    check("entry5_before_rst", rd_data1, 32'hAA);
    rst_n = 0; wr_en = 1; wr_addr = 6; wr_data = 32'h66; cycle();
    check("ready_in_rst", {31'd0, ready}, 32'd0);
    rst_n = 1; idle();
    rsv_en = 1; rsv_addr = 3; wr_en = 1; wr_addr = 7; wr_data = 32'h77;
    cycle();
    idle();
    wait_ready(edges);
    check("ready_latency_rst", edges, 31);
    rd_addr1 = 5; rd_addr2 = 3; cycle();
    check("entry5_cleared", rd_data1, 32'd0);
    check("busy2_rsv_in_clear", {31'd0, busy2}, 32'd0);
    rd_addr1 = 6; rd_addr2 = 7; cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
